fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC sequencing with predictor steering, feeding a fetch queue to decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] bp_pc,
    input  logic        bp_predicted_outcome,
    input  logic [31:0] bp_predicted_target,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        dq_valid,
    input  logic        dq_ready,
    output logic [31:0] dq_instr,
    output logic [31:0] dq_pc,
    output logic        dq_pred_taken,
    output logic [31:0] dq_pred_target
);

    localparam int               PTR_W      = $clog2(FQ_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FQ_DEPTH);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fq_entry_t;

    logic [0:0]       state;
    logic [0:0]       next_state;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             fetch;
    logic             pop;
    fq_entry_t        storage [FQ_DEPTH];
    fq_entry_t        head_entry;
    fq_entry_t        new_entry;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (halt && !redirect) next_state = HALTED;
            HALTED:  if (redirect)          next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if ((state == RUN) && !halt && !redirect && !full) begin
            imem_req = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshakes; a redirect squashes both queue operations
    // ------------------------------------------------------------------
    assign full     = (count == FULL_COUNT);
    assign dq_valid = (count != '0);
    assign fetch    = imem_req && imem_ready;
    assign pop      = dq_valid && dq_ready && !redirect;

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (fetch) begin
            pc_next = bp_predicted_outcome ? bp_predicted_target : (pc + 32'd4);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign imem_addr = pc;
    assign bp_pc     = pc;

    // ------------------------------------------------------------------
    // Queue pointers and occupancy; pointers wrap naturally at a power of two
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fetch) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({fetch, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (not reset: occupancy alone decides validity)
    // ------------------------------------------------------------------
    always_comb begin
        new_entry.instr       = imem_rdata;
        new_entry.pc          = pc;
        new_entry.pred_taken  = bp_predicted_outcome;
        new_entry.pred_target = bp_predicted_target;
    end

    always_ff @(posedge CLK) begin
        if (fetch) begin
            storage[tail] <= new_entry;
        end
    end

    assign head_entry     = storage[head];
    assign dq_instr       = head_entry.instr;
    assign dq_pc          = head_entry.pc;
    assign dq_pred_taken  = head_entry.pred_taken;
    assign dq_pred_target = head_entry.pred_target;

endmodule
`default_nettype wire
